flash_read_ctrl: RTL and testbench
==================================

# flash_read_ctrl

Sequencer for W25Qxx-family SPI flash read transactions. It sits between on-chip consumers (boot loader, configuration fetch) and the flash pins. It accepts one read request at a time (start address, byte count), issues the read command and 24-bit address in SPI mode 0, and streams the returned bytes out as one-cycle strobes. It is the single owner of the flash SPI pins once power-up ID checking has finished.

## Interface
- `SCK_HALF`, 1 — clk cycles per SCK half-period; must be ≥1.
- `CS_GAP`, 4 — minimum clk cycles `spi_ss` stays high between transactions; must be ≥1.
- `clk` in 1 — single clock; all logic on rising edge.
- `rst` in 1 — reset; synchronous, active-high.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — high only in IDLE; a transfer is accepted on `req_valid && req_ready`.
- `req_addr` in 24 — flash byte address; captured at accept.
- `req_len` in 16 — byte count; captured at accept.
- `rd_valid` out 1 — one-cycle strobe; `rd_data` is valid. There is no backpressure.
- `rd_data` out 8 — received byte, MSB first on the wire.
- `rd_last` out 1 — high together with `rd_valid` on the final byte.
- `done` out 1 — one-cycle pulse when the transaction completes.
- `spi_ss` out 1 — chip select, active low.
- `spi_sck` out 1 — SPI clock, idle low.
- `spi_mosi` out 1 — data to flash.
- `spi_miso` in 1 — data from flash.

## Operation
- All outputs are registered.
- Reset values:
  - `spi_ss`=1, `spi_sck`=0, `spi_mosi`=0.
  - `req_ready`=0; it rises one cycle after `rst` falls.
  - `rd_valid`=0, `rd_last`=0, `rd_data`=0, `done`=0.
- States: IDLE → SETUP → CMD → ADDR → [DUMMY] → DATA → HOLD → GAP → IDLE.
- IDLE: `req_ready`=1. On accept, capture `req_addr`/`req_len`.
  - `req_len`=0: go directly to GAP. `done` pulses the next cycle. `spi_ss` never falls.
  - Otherwise: go to SETUP.
- SETUP: `spi_ss`=0, `spi_sck`=0, `spi_mosi`=command bit 7; lasts 2·`SCK_HALF` cycles.
- Bit slot (CMD/ADDR/DUMMY/DATA), 2·`SCK_HALF` cycles each:
  - First `SCK_HALF` cycles: `sck`=0; `mosi` changes only at slot start.
  - Next `SCK_HALF` cycles: `sck`=1.
  - `spi_miso` is sampled on the edge that returns `sck` to 0.
- CMD: 8 bits, command 0x03, MSB first.
- ADDR: 24 bits of the captured address, MSB first.
- DATA: 8·len bits. `mosi`=0 throughout.
  - Shift in MSB first.
  - After each 8th sample, `rd_valid` pulses the next cycle. `rd_last` accompanies byte number len.
- HOLD: `sck`=0, `ss`=0 for `SCK_HALF` cycles; then `spi_ss`=1 and `done`=1 on the same edge.
- GAP: `spi_ss`=1, `req_ready`=0 for `CS_GAP` cycles; then IDLE.
- Address overflow is not checked. The 24-bit address is sent as given, and the flash's internal wrap applies.
- `req_valid` outside IDLE is ignored; nothing is queued.
- A reset asserted in any state forces reset values on the next edge:
  - `spi_ss` rises immediately.
  - No `done`; no further `rd_valid`.

## Timing
- Accept at edge T. `spi_ss` falls at T+1.
- Bit counts: B = 32 + 8·len, or 40 + 8·len with fast read.
- `done` at T + 1 + 2H + 2H·B + H, with H = `SCK_HALF`.
- Next accept is possible no earlier than `done` + `CS_GAP` + 1.
- Worked example, H=1, len=1: `done` at T+84. `rd_valid` at T+83, one cycle before `done`.
- Byte k (1-based) `rd_valid` = 1 clk after the edge that samples its bit 0.
- `spi_mosi` changes only while `spi_sck`=0.

## Configuration
- `FLASH_FAST_READ_EN` defined:
  - Command is 0x0B.
  - A DUMMY phase of 8 bit slots (`mosi`=0, `miso` ignored) is inserted between ADDR and DATA.
- Undefined: command 0x03, no DUMMY state; the state is removed from the encoding.

## Structure
- Package `flash_spi_pkg`:
  - state enum;
  - `CMD_READ`=8'h03, `CMD_FAST_READ`=8'h0B;
  - phase bit-count constants (8, 24, 8).
- Sub-module `flash_sck_gen`: a divider counter producing `rise`/`fall` strobes and the `sck` level from `SCK_HALF`; enabled only while a transaction runs. The controller FSM consumes the strobes.

## Test plan
- H=1, addr 0x000000, len=1, flash model returns 0xA5 → MOSI carries 0x03,0x00,0x00,0x00; `rd_data`=0xA5 with `rd_last`=1 at T+83; `done` at T+84.
- addr 0x123456, len=3, model returns 0x11,0x22,0x33 → three `rd_valid` strobes 16 clk apart, `rd_last` only on 0x33, `done` once.
- len=0 → `spi_ss` stays 1, `done` at T+1, `req_ready` back after `CS_GAP`.
- `rst` pulsed during DATA of a len=4 read → `spi_ss`=1 and `sck`=0 next edge, no `done`, no further `rd_valid`; a fresh request afterwards completes normally.
- H=2, `req_valid` held high throughout → each SCK phase is 2 clk; back-to-back transactions are separated by ≥`CS_GAP` cycles of `spi_ss`=1.
- `FLASH_FAST_READ_EN` defined, len=1 → command 0x0B, 8 dummy slots, `done` at T+100 (H=1), data correct.

Source files
------------

// File: rtl/flash_spi_pkg.sv
// Shared types and constants for the SPI flash read sequencer.
// FLASH_FAST_READ_EN selects fast read (0x0B plus dummy phase).
package flash_spi_pkg;

`ifdef FLASH_FAST_READ_EN
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CMD, S_ADDR,
        S_DUMMY, S_DATA, S_HOLD, S_GAP
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CMD, S_ADDR,
        S_DATA, S_HOLD, S_GAP
    } state_e;
`endif

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    localparam int CMD_BITS   = 8;
    localparam int ADDR_BITS  = 24;
    localparam int DUMMY_BITS = 8;

    function automatic logic [4:0] last_bit(input int n);
        return 5'(n - 1);
    endfunction

endpackage

// File: rtl/flash_sck_gen.sv
// SCK divider: one bit slot is 2*SCK_HALF cycles, low half first.
// rise/fall flag the edges on which sck goes high/low.
module flash_sck_gen #(
    parameter int SCK_HALF = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic quiet,
    output logic rise,
    output logic fall,
    output logic sck
);

    localparam int CW = $clog2(2 * SCK_HALF + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;

    assign rise = en && (cnt_q == CW'(SCK_HALF - 1));
    assign fall = en && (cnt_q == CW'(2 * SCK_HALF - 1));
    assign sck  = sck_q;

    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!en) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else begin
            cnt_d = fall ? '0 : cnt_q + CW'(1);
            // quiet slots still count time but keep the pin low
            if (quiet)     sck_d = 1'b0;
            else if (rise) sck_d = 1'b1;
            else if (fall) sck_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/flash_read_ctrl.sv
// W25Qxx read sequencer, SPI mode 0, one request at a time.
// FLASH_FAST_READ_EN: command 0x0B with 8 dummy slots.
module flash_read_ctrl #(
    parameter int SCK_HALF = 1,
    parameter int CS_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_len,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        rd_last,
    output logic        done,
    output logic        spi_ss,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    import flash_spi_pkg::*;

`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] CMD = CMD_FAST_READ;
`else
    localparam logic [7:0] CMD = CMD_READ;
`endif
    localparam int GW = $clog2(CS_GAP + 1);

    state_e        state_q, state_d;
    logic [31:0]   tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic [4:0]    bit_q, bit_d;
    logic [15:0]   len_q, len_d;
    logic          zlen_q, zlen_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          ss_q, ss_d;
    logic          mosi_q, mosi_d;
    logic          ready_q, ready_d;
    logic          rdv_q, rdv_d;
    logic [7:0]    rdd_q, rdd_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic          rise, fall, gen_en, gen_quiet;

    // counting starts the cycle after ss has actually fallen
    assign gen_en    = !ss_q && state_q != S_IDLE
                       && state_q != S_GAP;
    assign gen_quiet = state_q == S_SETUP || state_q == S_HOLD;

    flash_sck_gen #(.SCK_HALF(SCK_HALF)) u_sck (
        .clk   (clk),
        .rst   (rst),
        .en    (gen_en),
        .quiet (gen_quiet),
        .rise  (rise),
        .fall  (fall),
        .sck   (spi_sck)
    );

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        len_d   = len_q;
        zlen_d  = zlen_q;
        gap_d   = '0;
        ss_d    = ss_q;
        mosi_d  = mosi_q;
        rdv_d   = 1'b0;
        rdd_d   = rdd_q;
        last_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ss_d   = 1'b1;
                mosi_d = 1'b0;
                if (req_valid && ready_q) begin
                    tx_d    = {CMD, req_addr};
                    len_d   = req_len;
                    zlen_d  = req_len == 16'd0;
                    bit_d   = '0;
                    state_d = (req_len == 16'd0) ? S_GAP : S_SETUP;
                end
            end
            S_SETUP: begin
                ss_d   = 1'b0;
                mosi_d = tx_q[31];
                if (fall) state_d = S_CMD;
            end
            S_CMD: if (fall) begin
                tx_d   = {tx_q[30:0], 1'b0};
                mosi_d = tx_q[30];
                bit_d  = bit_q + 5'd1;
                if (bit_q == last_bit(CMD_BITS)) begin
                    bit_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: if (fall) begin
                tx_d   = {tx_q[30:0], 1'b0};
                mosi_d = tx_q[30];
                bit_d  = bit_q + 5'd1;
                if (bit_q == last_bit(ADDR_BITS)) begin
                    bit_d   = '0;
                    mosi_d  = 1'b0;
`ifdef FLASH_FAST_READ_EN
                    state_d = S_DUMMY;
`else
                    state_d = S_DATA;
`endif
                end
            end
`ifdef FLASH_FAST_READ_EN
            S_DUMMY: if (fall) begin
                mosi_d = 1'b0;
                bit_d  = bit_q + 5'd1;
                if (bit_q == last_bit(DUMMY_BITS)) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
`endif
            S_DATA: begin
                mosi_d = 1'b0;
                if (fall) begin
                    rx_d  = {rx_q[6:0], spi_miso};
                    bit_d = bit_q + 5'd1;
                    if (bit_q == 5'd7) begin
                        bit_d = '0;
                        rdv_d = 1'b1;
                        rdd_d = {rx_q[6:0], spi_miso};
                        len_d = len_q - 16'd1;
                        if (len_q == 16'd1) begin
                            last_d  = 1'b1;
                            state_d = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: if (rise) begin
                ss_d    = 1'b1;
                done_d  = 1'b1;
                state_d = S_GAP;
            end
            S_GAP: begin
                ss_d = 1'b1;
                // zero-length: done one cycle late, gap counts from it
                if (zlen_q) begin
                    done_d = 1'b1;
                    zlen_d = 1'b0;
                end else if (gap_q == GW'(CS_GAP - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = state_d == S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            len_q   <= '0;
            zlen_q  <= 1'b0;
            gap_q   <= '0;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
            ready_q <= 1'b0;
            rdv_q   <= 1'b0;
            rdd_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            len_q   <= len_d;
            zlen_q  <= zlen_d;
            gap_q   <= gap_d;
            ss_q    <= ss_d;
            mosi_q  <= mosi_d;
            ready_q <= ready_d;
            rdv_q   <= rdv_d;
            rdd_q   <= rdd_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign req_ready = ready_q;
    assign rd_valid  = rdv_q;
    assign rd_data   = rdd_q;
    assign rd_last   = last_q;
    assign done      = done_q;
    assign spi_ss    = ss_q;
    assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Directed bench for flash_read_ctrl with a small W25Qxx read model.
// Follows FLASH_FAST_READ_EN for command and dummy-phase timing.
module tb_flash_read_ctrl;

    localparam int H  = 1;
    localparam int H2 = 2;
    localparam int GAP = 4;
`ifdef FLASH_FAST_READ_EN
    localparam int HDR = 40;
    localparam logic [7:0] EXP_CMD = 8'h0B;
`else
    localparam int HDR = 32;
    localparam logic [7:0] EXP_CMD = 8'h03;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic [15:0] req_len = '0;
    logic        rd_valid, rd_last, done;
    logic [7:0]  rd_data;
    logic        spi_ss, spi_sck, spi_mosi;
    logic        miso = 1'b0;

    logic        b_rst = 1'b1;
    logic        b_req_valid = 1'b0;
    logic        b_req_ready, b_rd_valid, b_rd_last, b_done;
    logic [7:0]  b_rd_data;
    logic        b_ss, b_sck, b_mosi;

    always #5 clk = ~clk;

    flash_read_ctrl #(.SCK_HALF(H), .CS_GAP(GAP)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .done(done),
        .spi_ss(spi_ss), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_miso(miso)
    );

    flash_read_ctrl #(.SCK_HALF(H2), .CS_GAP(GAP)) u_dut2 (
        .clk(clk), .rst(b_rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_addr(24'h000010), .req_len(16'd1),
        .rd_valid(b_rd_valid), .rd_data(b_rd_data),
        .rd_last(b_rd_last), .done(b_done),
        .spi_ss(b_ss), .spi_sck(b_sck),
        .spi_mosi(b_mosi), .spi_miso(1'b1)
    );

    // flash model: shifts in on sck rise, drives data after sck fall
    logic [7:0]  mem [4];
    logic [31:0] mdl_hdr = '0;
    int          rcnt = 0;
    int          dbit;

    always @(negedge spi_ss or posedge spi_sck) begin
        if (spi_sck) begin
            if (rcnt < 32) mdl_hdr = {mdl_hdr[30:0], spi_mosi};
            rcnt = rcnt + 1;
        end else begin
            rcnt = 0;
        end
    end

    always @(negedge spi_sck) begin
        if (!spi_ss && rcnt >= HDR) begin
            dbit = rcnt - HDR;
            if (dbit / 8 < 4) miso = mem[dbit/8][7 - dbit%8];
            else              miso = 1'b0;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // continuous monitors: mosi stability, H=2 phase/gap/period
    int  cyc = 0, mviol = 0;
    logic pm = 1'b0, pbm = 1'b0;
    int  b_hi = 0, b_hmin = 1000, b_hmax = 0;
    int  b_sh = 0, b_shmin = 1000;
    int  b_dn = 0, b_lastd = 0, b_per = 0, b_bad = 0;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (spi_mosi != pm && spi_sck) mviol++;
        if (b_mosi != pbm && b_sck) mviol++;
        pm = spi_mosi;
        pbm = b_mosi;
        if (!b_rst) begin
            if (b_sck) b_hi++;
            else if (b_hi > 0) begin
                if (b_hi < b_hmin) b_hmin = b_hi;
                if (b_hi > b_hmax) b_hmax = b_hi;
                b_hi = 0;
            end
            if (b_ss) b_sh++;
            else if (b_sh > 0) begin
                if (b_dn > 0 && b_sh < b_shmin) b_shmin = b_sh;
                b_sh = 0;
            end
            if (b_done) begin
                if (b_dn > 0) b_per = cyc - b_lastd;
                b_lastd = cyc;
                b_dn++;
            end
            if (b_rd_valid && (b_rd_data != 8'hFF || !b_rd_last))
                b_bad++;
        end
    end

    task automatic accept(input logic [23:0] a, input logic [15:0] n);
        int to;
        to = 0;
        while (!req_ready && to < 200) begin
            tick;
            to++;
        end
        check("rdy_wait", 32'(req_ready), 32'd1);
        req_addr = a;
        req_len = n;
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        check("ss_at_T", 32'(spi_ss), 32'd1);
    endtask

    task automatic run_read(input logic [23:0] a, input logic [15:0] n);
        int nb, drel, rrel, sslow;
        accept(a, n);
        nb = 0; drel = -1; rrel = -1; sslow = 0;
        for (int c = 1; c < 600 && rrel < 0; c++) begin
            tick;
            if (c == 1)
                check("ss_T1", 32'(spi_ss), (n == 0) ? 32'd1 : 32'd0);
            if (!spi_ss) sslow = 1;
            if (rd_valid) begin
                if (nb < 4) check("rd_data", 32'(rd_data), 32'(mem[nb]));
                check("rd_last", 32'(rd_last),
                      (nb == int'(n) - 1) ? 32'd1 : 32'd0);
                check("rd_time", 32'(c),
                      32'(1 + 2*H + 2*H*(HDR + 8*(nb + 1))));
                nb++;
            end
            if (done) begin
                if (drel >= 0) check("done_once", 32'd2, 32'd1);
                drel = c;
            end
            if (req_ready && drel >= 0) rrel = c;
        end
        check("nbytes", 32'(nb), 32'(n));
        check("done_t", 32'(drel),
              (n == 0) ? 32'd1 : 32'(1 + 3*H + 2*H*(HDR + 8*int'(n))));
        check("ready_t", 32'(rrel), 32'(drel + GAP));
        if (n == 0) check("ss_stay_hi", 32'(sslow), 32'd0);
        else begin
            check("cmd", 32'(mdl_hdr[31:24]), 32'(EXP_CMD));
            check("addr", 32'(mdl_hdr[23:0]), 32'(a));
        end
    endtask

    initial begin : main
        int nrdv, ndone, got;
        repeat (3) tick;
        check("rst_ss", 32'(spi_ss), 32'd1);
        check("rst_sck", 32'(spi_sck), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rdv", 32'(rd_valid), 32'd0);
        check("rst_rdd", 32'(rd_data), 32'd0);
        check("rst_last", 32'(rd_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        b_rst = 1'b0;
        b_req_valid = 1'b1;
        tick;
        check("ready_rise", 32'(req_ready), 32'd1);

        mem = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_read(24'h000000, 16'd1);

        mem = '{8'h11, 8'h22, 8'h33, 8'h00};
        run_read(24'h123456, 16'd3);

        run_read(24'h000abc, 16'd0);

        mem = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        accept(24'h000100, 16'd4);
        got = 0;
        for (int c = 0; c < 400 && got == 0; c++) begin
            tick;
            if (rd_valid) got = 1;
        end
        check("rst_reach_data", 32'(got), 32'd1);
        rst = 1'b1;
        tick;
        check("rst_mid_ss", 32'(spi_ss), 32'd1);
        check("rst_mid_sck", 32'(spi_sck), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        nrdv = 0;
        ndone = 0;
        for (int c = 0; c < 300; c++) begin
            tick;
            if (rd_valid) nrdv++;
            if (done) ndone++;
        end
        check("rst_no_rdv", 32'(nrdv), 32'd0);
        check("rst_no_done", 32'(ndone), 32'd0);

        mem = '{8'h5A, 8'hC3, 8'h00, 8'h00};
        run_read(24'hABCDEF, 16'd2);

        while (b_dn < 3 && cyc < 5000) tick;
        check("b_dones", 32'(b_dn >= 3), 32'd1);
        check("b_sck_hmin", 32'(b_hmin), 32'(H2));
        check("b_sck_hmax", 32'(b_hmax), 32'(H2));
        check("b_gap_min", 32'(b_shmin >= GAP), 32'd1);
        check("b_period", 32'(b_per),
              32'((1 + 3*H2 + 2*H2*(HDR + 8)) + GAP + 1));
        check("b_data", 32'(b_bad), 32'd0);
        check("mosi_stable", 32'(mviol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
